// File: rtl/pipelined_divider.sv
// rtl/pipelined_divider.sv - fully pipelined signed restoring divider with tag sideband and stall
// Quotient truncates toward zero; the remainder takes the numerator's sign.
module pipelined_divider #(
  parameter int NUM_W    = 32,
  parameter int DEN_W    = 22,
  parameter int OUT_W    = 20,
  parameter int BPS      = 8,
  parameter int TAG_W    = 8,
  parameter bit SATURATE = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_enable,
  input  logic             i_valid,
  input  logic [NUM_W-1:0] i_numer,
  input  logic [DEN_W-1:0] i_denom,
  input  logic [TAG_W-1:0] i_tag,
  output logic             o_valid,
  output logic [OUT_W-1:0] o_quot,
  output logic [DEN_W-1:0] o_rem,
  output logic [TAG_W-1:0] o_tag,
  output logic             o_divzero,
  output logic             o_ovf
);

  localparam int STAGES = NUM_W / BPS;

  localparam logic signed [NUM_W:0] Q_MAX = {{(NUM_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [NUM_W:0] Q_MIN = {{(NUM_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};
  localparam logic [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

  // Index 0 is the operand-conditioning stage, 1..STAGES the division stages.
  logic [STAGES:0]    v;
  logic [STAGES:0]    neg_q;
  logic [STAGES:0]    neg_r;
  logic [STAGES:0]    dz;
  logic [NUM_W-1:0]   dq      [0:STAGES];
  logic [DEN_W-1:0]   rem     [0:STAGES];
  logic [DEN_W-1:0]   den_abs [0:STAGES-1];
  logic [TAG_W-1:0]   tag     [0:STAGES];

  logic [NUM_W-1:0]   nxt_dq  [1:STAGES];
  logic [DEN_W-1:0]   nxt_rem [1:STAGES];
  logic [DEN_W-1:0]   step_r;
  logic [NUM_W-1:0]   step_q;
  logic [DEN_W:0]     trial;

  // |-2^(NUM_W-1)| = 2^(NUM_W-1) still fits NUM_W bits when read as unsigned.
  logic [NUM_W-1:0]   numer_abs;
  logic [DEN_W-1:0]   denom_abs;

  always_comb begin
    numer_abs = i_numer[NUM_W-1] ? -i_numer : i_numer;
    denom_abs = i_denom[DEN_W-1] ? -i_denom : i_denom;
  end

  // dq shifts dividend bits out of its MSB and quotient bits into its LSB.
  // With a zero divisor every subtract is of 0, so the remainder ends up
  // holding the low DEN_W bits of |num|, which the sign fix turns into num.
  always_comb begin
    step_r = '0;
    step_q = '0;
    trial  = '0;
    for (int s = 1; s <= STAGES; s++) begin
      step_r = rem[s-1];
      step_q = dq[s-1];
      for (int b = 0; b < BPS; b++) begin
        trial  = {step_r, step_q[NUM_W-1]};
        step_q = {step_q[NUM_W-2:0], 1'b0};
        if (trial >= {1'b0, den_abs[s-1]}) begin
          trial     = trial - {1'b0, den_abs[s-1]};
          step_q[0] = 1'b1;
        end
        step_r = trial[DEN_W-1:0];
      end
      nxt_dq[s]  = step_q;
      nxt_rem[s] = step_r;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      v <= '0;
    end else if (i_enable) begin
      v <= {v[STAGES-1:0], i_valid};
    end
  end

  always_ff @(posedge clock) begin
    if (i_enable) begin
      dq[0]      <= numer_abs;
      rem[0]     <= '0;
      den_abs[0] <= denom_abs;
      tag[0]     <= i_tag;
      neg_q      <= {neg_q[STAGES-1:0], i_numer[NUM_W-1] ^ i_denom[DEN_W-1]};
      neg_r      <= {neg_r[STAGES-1:0], i_numer[NUM_W-1]};
      dz         <= {dz[STAGES-1:0], (i_denom == '0)};
      for (int s = 1; s <= STAGES; s++) begin
        dq[s]  <= nxt_dq[s];
        rem[s] <= nxt_rem[s];
        tag[s] <= tag[s-1];
      end
      for (int s = 1; s < STAGES; s++) begin
        den_abs[s] <= den_abs[s-1];
      end
    end
  end

  logic [NUM_W:0]        q_ext;
  logic signed [NUM_W:0] q_signed;
  logic                  ovf_n;
  logic [OUT_W-1:0]      quot_n;
  logic [DEN_W-1:0]      rem_n;

  always_comb begin
    q_ext    = {1'b0, dq[STAGES]};
    q_signed = neg_q[STAGES] ? -q_ext : q_ext;
    rem_n    = neg_r[STAGES] ? -rem[STAGES] : rem[STAGES];
    ovf_n    = 1'b0;
    quot_n   = q_signed[OUT_W-1:0];
    if (dz[STAGES]) begin
      quot_n = neg_r[STAGES] ? OUT_MIN : OUT_MAX;
    end else if ((q_signed > Q_MAX) || (q_signed < Q_MIN)) begin
      ovf_n = 1'b1;
      if (SATURATE) begin
        quot_n = q_signed[NUM_W] ? OUT_MIN : OUT_MAX;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      o_valid   <= 1'b0;
      o_quot    <= '0;
      o_rem     <= '0;
      o_tag     <= '0;
      o_divzero <= 1'b0;
      o_ovf     <= 1'b0;
    end else if (i_enable) begin
      o_valid   <= v[STAGES];
      o_quot    <= quot_n;
      o_rem     <= rem_n;
      o_tag     <= tag[STAGES];
      o_divzero <= dz[STAGES];
      o_ovf     <= ovf_n;
    end
  end

endmodule

// File: tb/tb_pipelined_divider.sv
// tb/tb_pipelined_divider.sv - directed and streaming checks for pipelined_divider
// A saturating and a wrapping instance share the same stimulus.
module tb_pipelined_divider;

  logic        clock;
  logic        reset;
  logic        i_enable;
  logic        i_valid;
  logic [31:0] i_numer;
  logic [21:0] i_denom;
  logic [7:0]  i_tag;

  logic        o_valid,   w_valid;
  logic [19:0] o_quot,    w_quot;
  logic [21:0] o_rem,     w_rem;
  logic [7:0]  o_tag,     w_tag;
  logic        o_divzero, w_divzero;
  logic        o_ovf,     w_ovf;

  int tests;
  int fails;

  pipelined_divider #(.SATURATE(1'b1)) dut (
    .clock(clock), .reset(reset), .i_enable(i_enable), .i_valid(i_valid),
    .i_numer(i_numer), .i_denom(i_denom), .i_tag(i_tag),
    .o_valid(o_valid), .o_quot(o_quot), .o_rem(o_rem), .o_tag(o_tag),
    .o_divzero(o_divzero), .o_ovf(o_ovf)
  );

  pipelined_divider #(.SATURATE(1'b0)) dut_wrap (
    .clock(clock), .reset(reset), .i_enable(i_enable), .i_valid(i_valid),
    .i_numer(i_numer), .i_denom(i_denom), .i_tag(i_tag),
    .o_valid(w_valid), .o_quot(w_quot), .o_rem(w_rem), .o_tag(w_tag),
    .o_divzero(w_divzero), .o_ovf(w_ovf)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "watchdog");
  end

  // Independent reference: exact arithmetic on 64-bit integers.
  task automatic ref_div(input logic [31:0] n, input logic [21:0] d, input bit sat,
                         output logic [19:0] q, output logic [21:0] r,
                         output logic dzf, output logic ovf);
    longint ln, ld, lq, lr;
    ln = longint'($signed(n));
    ld = longint'($signed(d));
    if (ld == 0) begin
      dzf = 1'b1;
      ovf = 1'b0;
      q   = (ln < 0) ? 20'h80000 : 20'h7FFFF;
      r   = n[21:0];
    end else begin
      lq  = ln / ld;
      lr  = ln - lq * ld;
      dzf = 1'b0;
      ovf = (lq > 524287) || (lq < -524288);
      if (ovf && sat) q = (lq < 0) ? 20'h80000 : 20'h7FFFF;
      else            q = lq[19:0];
      r = lr[21:0];
    end
  endtask

  // Issue one op, then advance 6 edges; result must be absent until the 6th.
  task automatic run_op(input logic [31:0] n, input logic [21:0] d, input logic [7:0] t);
    @(negedge clock);
    i_enable = 1'b1;
    i_valid  = 1'b1;
    i_numer  = n;
    i_denom  = d;
    i_tag    = t;
    for (int e = 1; e <= 6; e++) begin
      @(posedge clock);
      #1;
      if (e == 1) i_valid = 1'b0;
      if (e < 6) begin
        tests++;
        if (o_valid !== 1'b0) begin
          fails++;
          $display("FAIL latency_early tag=%0h edge=%0d: o_valid=%b required 0", t, e, o_valid);
        end
      end
    end
  endtask

  task automatic test_reset;
    reset    = 1'b1;
    i_enable = 1'b1;
    i_valid  = 1'b1;
    i_numer  = 32'd1234;
    i_denom  = 22'd5;
    i_tag    = 8'hA5;
    repeat (3) @(posedge clock);
    #1;
    tests++;
    if ({o_valid, o_quot, o_rem, o_tag, o_divzero, o_ovf} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: v=%b q=%h r=%h t=%h dz=%b ovf=%b required all 0",
               o_valid, o_quot, o_rem, o_tag, o_divzero, o_ovf);
    end
    @(negedge clock);
    i_valid = 1'b0;
    reset   = 1'b0;
    repeat (7) @(posedge clock);
    #1;
    tests++;
    if (o_valid !== 1'b0) begin
      fails++;
      $display("FAIL idle_after_reset: o_valid=%b required 0", o_valid);
    end
  endtask

  task automatic test_basic;
    run_op(32'd1000, 22'd7, 8'h11);
    tests++;
    if ({o_valid, o_quot, o_rem, o_tag, o_divzero, o_ovf} !== {1'b1, 20'd142, 22'd6, 8'h11, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL basic_1000_7: v=%b q=%h r=%h t=%h dz=%b ovf=%b required v=1 q=0008e r=000006 t=11 dz=0 ovf=0",
               o_valid, o_quot, o_rem, o_tag, o_divzero, o_ovf);
    end
  endtask

  task automatic test_signs;
    logic [31:0] nv [3];
    logic [21:0] dv [3];
    logic [19:0] qv [3];
    logic [21:0] rv [3];
    nv[0] = 32'hFFFFFC18; dv[0] = 22'd7;       qv[0] = 20'hFFF72; rv[0] = 22'h3FFFFA;
    nv[1] = 32'd1000;     dv[1] = 22'h3FFFF9;  qv[1] = 20'hFFF72; rv[1] = 22'h000006;
    nv[2] = 32'hFFFFFC18; dv[2] = 22'h3FFFF9;  qv[2] = 20'h0008E; rv[2] = 22'h3FFFFA;
    for (int i = 0; i < 3; i++) begin
      run_op(nv[i], dv[i], 8'(8'h20 + i));
      tests++;
      if ({o_valid, o_quot, o_rem, o_divzero, o_ovf} !== {1'b1, qv[i], rv[i], 1'b0, 1'b0}) begin
        fails++;
        $display("FAIL sign_case%0d: v=%b q=%h r=%h dz=%b ovf=%b required v=1 q=%h r=%h dz=0 ovf=0",
                 i, o_valid, o_quot, o_rem, o_divzero, o_ovf, qv[i], rv[i]);
      end
    end
  endtask

  task automatic test_divzero;
    logic [31:0] nv [3];
    logic [19:0] qv [3];
    logic [21:0] rv [3];
    nv[0] = 32'd5;        qv[0] = 20'h7FFFF; rv[0] = 22'h000005;
    nv[1] = 32'hFFFFFFFB; qv[1] = 20'h80000; rv[1] = 22'h3FFFFB;
    nv[2] = 32'd0;        qv[2] = 20'h7FFFF; rv[2] = 22'h000000;
    for (int i = 0; i < 3; i++) begin
      run_op(nv[i], 22'd0, 8'(8'h30 + i));
      tests++;
      if ({o_valid, o_quot, o_rem, o_divzero, o_ovf} !== {1'b1, qv[i], rv[i], 1'b1, 1'b0}) begin
        fails++;
        $display("FAIL divzero_case%0d: v=%b q=%h r=%h dz=%b ovf=%b required v=1 q=%h r=%h dz=1 ovf=0",
                 i, o_valid, o_quot, o_rem, o_divzero, o_ovf, qv[i], rv[i]);
      end
      tests++;
      if ({w_quot, w_divzero, w_ovf} !== {qv[i], 1'b1, 1'b0}) begin
        fails++;
        $display("FAIL divzero_wrap_case%0d: q=%h dz=%b ovf=%b required q=%h dz=1 ovf=0",
                 i, w_quot, w_divzero, w_ovf, qv[i]);
      end
    end
  endtask

  task automatic test_overflow;
    logic [31:0] nv [5];
    logic [21:0] dv [5];
    logic [19:0] sq [5];
    logic [19:0] wq [5];
    logic        ov [5];
    nv[0] = 32'h10000000; dv[0] = 22'd1;      sq[0] = 20'h7FFFF; wq[0] = 20'h00000; ov[0] = 1'b1;
    nv[1] = 32'h80000000; dv[1] = 22'h3FFFFF; sq[1] = 20'h7FFFF; wq[1] = 20'h00000; ov[1] = 1'b1;
    nv[2] = 32'h0007FFFF; dv[2] = 22'd1;      sq[2] = 20'h7FFFF; wq[2] = 20'h7FFFF; ov[2] = 1'b0;
    nv[3] = 32'hFFF80000; dv[3] = 22'd1;      sq[3] = 20'h80000; wq[3] = 20'h80000; ov[3] = 1'b0;
    nv[4] = 32'h00080000; dv[4] = 22'd1;      sq[4] = 20'h7FFFF; wq[4] = 20'h80000; ov[4] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      run_op(nv[i], dv[i], 8'(8'h40 + i));
      tests++;
      if ({o_valid, o_quot, o_rem, o_divzero, o_ovf} !== {1'b1, sq[i], 22'd0, 1'b0, ov[i]}) begin
        fails++;
        $display("FAIL ovf_sat_case%0d: v=%b q=%h r=%h dz=%b ovf=%b required v=1 q=%h r=0 dz=0 ovf=%b",
                 i, o_valid, o_quot, o_rem, o_divzero, o_ovf, sq[i], ov[i]);
      end
      tests++;
      if ({w_valid, w_quot, w_rem, w_divzero, w_ovf} !== {1'b1, wq[i], 22'd0, 1'b0, ov[i]}) begin
        fails++;
        $display("FAIL ovf_wrap_case%0d: v=%b q=%h r=%h dz=%b ovf=%b required v=1 q=%h r=0 dz=0 ovf=%b",
                 i, w_valid, w_quot, w_rem, w_divzero, w_ovf, wq[i], ov[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    for (int e = 1; e <= 9; e++) begin
      @(negedge clock);
      i_enable = 1'b1;
      i_valid  = (e <= 4);
      i_numer  = 32'(e * 100 + 3);
      i_denom  = 22'd10;
      i_tag    = 8'(8'h50 + e);
      @(posedge clock);
      #1;
      if (e >= 6) begin
        tests++;
        if ({o_valid, o_quot, o_rem, o_tag} !== {1'b1, 20'((e - 5) * 10), 22'd3, 8'(8'h50 + e - 5)}) begin
          fails++;
          $display("FAIL back_to_back edge=%0d: v=%b q=%0d r=%0d t=%h required v=1 q=%0d r=3 t=%h",
                   e, o_valid, o_quot, o_rem, o_tag, (e - 5) * 10, 8'h50 + e - 5);
        end
      end
    end
    @(negedge clock);
    i_valid = 1'b0;
  endtask

  task automatic test_streaming;
    bit          mv [6];
    logic [31:0] mn [6];
    logic [21:0] md [6];
    logic [7:0]  mt [6];
    logic [63:0] prev;
    logic [19:0] eq;
    logic [21:0] er;
    logic        edz, eovf;
    logic        en;
    int          issued, got, cyc;
    for (int k = 0; k < 6; k++) begin
      mv[k] = 1'b0; mn[k] = '0; md[k] = '0; mt[k] = '0;
    end
    issued = 0;
    got    = 0;
    cyc    = 0;
    while (got < 64 && cyc < 3000) begin
      @(negedge clock);
      en       = 1'($urandom_range(0, 1));
      i_enable = en;
      i_valid  = (issued < 64);
      i_numer  = $urandom;
      case ($urandom_range(0, 3))
        0:       i_denom = ($urandom_range(0, 1) != 0) ? 22'($urandom_range(1, 50)) : -22'($urandom_range(1, 50));
        1:       i_denom = 22'($urandom);
        2:       i_denom = 22'd0;
        default: i_denom = {{6{i_numer[3]}}, 16'($urandom)};
      endcase
      i_tag = 8'(issued);
      prev  = {o_valid, o_quot, o_rem, o_tag, o_divzero, o_ovf, 11'd0};
      @(posedge clock);
      #1;
      if (en) begin
        for (int k = 5; k > 0; k--) begin
          mv[k] = mv[k-1]; mn[k] = mn[k-1]; md[k] = md[k-1]; mt[k] = mt[k-1];
        end
        mv[0] = i_valid; mn[0] = i_numer; md[0] = i_denom; mt[0] = i_tag;
        if (i_valid) issued++;
        tests++;
        if (o_valid !== mv[5]) begin
          fails++;
          $display("FAIL stream_valid cycle=%0d: o_valid=%b required %b", cyc, o_valid, mv[5]);
        end else if (mv[5]) begin
          ref_div(mn[5], md[5], 1'b1, eq, er, edz, eovf);
          tests++;
          if ({o_quot, o_rem, o_tag, o_divzero, o_ovf} !== {eq, er, 8'(got), edz, eovf}) begin
            fails++;
            $display("FAIL stream_result n=%h d=%h: q=%h r=%h t=%h dz=%b ovf=%b required q=%h r=%h t=%h dz=%b ovf=%b",
                     mn[5], md[5], o_quot, o_rem, o_tag, o_divzero, o_ovf, eq, er, 8'(got), edz, eovf);
          end
          got++;
        end
      end else begin
        tests++;
        if ({o_valid, o_quot, o_rem, o_tag, o_divzero, o_ovf, 11'd0} !== prev) begin
          fails++;
          $display("FAIL stream_frozen cycle=%0d: outputs=%h required held %h", cyc,
                   {o_valid, o_quot, o_rem, o_tag, o_divzero, o_ovf, 11'd0}, prev);
        end
      end
      cyc++;
    end
    tests++;
    if (got != 64) begin
      fails++;
      $display("FAIL stream_count: received %0d results required 64", got);
    end
    @(negedge clock);
    i_enable = 1'b1;
    i_valid  = 1'b0;
    repeat (8) @(posedge clock);
  endtask

  task automatic test_reset_midflight;
    for (int e = 1; e <= 6; e++) begin
      @(negedge clock);
      i_enable = 1'b1;
      i_valid  = (e <= 3);
      i_numer  = 32'(e * 50);
      i_denom  = 22'd5;
      i_tag    = 8'(8'h60 + e);
      @(posedge clock);
    end
    #1;
    tests++;
    if ({o_valid, o_tag} !== {1'b1, 8'h61}) begin
      fails++;
      $display("FAIL midflight_first_result: v=%b t=%h required v=1 t=61", o_valid, o_tag);
    end
    #2;
    reset = 1'b1;
    #1;
    tests++;
    if ({o_valid, o_quot, o_rem, o_tag, o_divzero, o_ovf} !== '0) begin
      fails++;
      $display("FAIL midflight_async_clear: v=%b q=%h r=%h t=%h required all 0", o_valid, o_quot, o_rem, o_tag);
    end
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clock);
      #1;
      tests++;
      if (o_valid !== 1'b0) begin
        fails++;
        $display("FAIL midflight_stale cycle=%0d: o_valid=%b t=%h required 0", c, o_valid, o_tag);
      end
    end
  endtask

  initial begin
    tests    = 0;
    fails    = 0;
    reset    = 1'b1;
    i_enable = 1'b0;
    i_valid  = 1'b0;
    i_numer  = '0;
    i_denom  = '0;
    i_tag    = '0;
    test_reset;
    test_basic;
    test_signs;
    test_divzero;
    test_overflow;
    test_back_to_back;
    test_streaming;
    test_reset_midflight;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipelined_divider.md
Name: pipelined_divider

Overview:
- Parametrised, fully pipelined signed integer divider for the GPU setup and interpolation path. Successor of the fixed 6-cycle 32/22→20 divide unit.
- Adds:
  - valid/tag sideband
  - pipeline-wide clock enable (stall)
  - remainder output
  - explicit divide-by-zero handling
  - selectable saturation or wrap of the narrowed quotient
- One result per clock at full throughput. Results leave in issue order.

Parameters:
- NUM_W, 32: numerator width, signed.
- DEN_W, 22: denominator width, signed. Must satisfy DEN_W ≤ NUM_W.
- OUT_W, 20: quotient output width, signed. Must satisfy OUT_W ≤ NUM_W.
- BPS, 8: quotient bits resolved per pipeline stage. NUM_W % BPS must be 0.
- TAG_W, 8: width of the sideband tag carried alongside each operation.
- SATURATE, 1: 1 = clamp the quotient to the OUT_W signed range; 0 = keep the low OUT_W bits (legacy wrap).

Ports:
- clock, in, 1: rising-edge clock.
- reset, in, 1: asynchronous, active-high reset.
- i_enable, in, 1: pipeline advance. 0 freezes every stage.
- i_valid, in, 1: operation present on the inputs.
- i_numer, in, NUM_W: signed numerator.
- i_denom, in, DEN_W: signed denominator.
- i_tag, in, TAG_W: opaque tag, returned unchanged with the result.
- o_valid, out, 1: result present.
- o_quot, out, OUT_W: signed quotient, truncated toward zero, then saturated or wrapped.
- o_rem, out, DEN_W: signed remainder; its sign follows the numerator.
- o_tag, out, TAG_W: tag of the operation whose result is on the outputs.
- o_divzero, out, 1: denominator was 0.
- o_ovf, out, 1: the exact quotient did not fit in OUT_W signed. Reported regardless of SATURATE.

Behaviour:
- Reset: asynchronous and active-high. While reset is high:
  - all stage valid bits are 0
  - o_valid=0, o_quot=0, o_rem=0, o_tag=0, o_divzero=0, o_ovf=0
- Reset asserted mid-operation discards every in-flight operation. No result from before reset ever appears after release.
- Stage data registers need no reset; only valid bits and output registers are reset.
- Latency LAT = NUM_W/BPS + 2 cycles of i_enable=1. Default LAT = 6.
  - Stage 0: register the absolute values (NUM_W+1 bits, so that -2^(NUM_W-1) is representable), the result sign (num_sign XOR den_sign), num_sign, a zero-denominator flag, the tag and valid.
  - Stages 1..NUM_W/BPS: restoring division, BPS quotient bits per stage, MSB first. Each iteration compares the partial remainder against |den| and subtracts when it is not smaller.
  - Final stage:
    - apply the sign to the quotient and remainder
    - detect overflow
    - saturate or wrap
    - register the outputs
- Enable and throughput:
  - An operation with i_valid=1 sampled at a clock edge with i_enable=1 emerges exactly LAT enabled edges later.
  - i_enable=0: all registers, including the outputs, hold. Inputs are ignored on that edge.
  - With i_enable held at 1 there are no bubbles: one issue per cycle yields one result per cycle.
  - i_valid=0 issues propagate as o_valid=0. Output data during o_valid=0 is don't-care.
- Arithmetic:
  - Quotient truncates toward zero.
  - rem = num - quot*den (exact, pre-narrowing quotient); |rem| < |den|.
  - Examples: -7/2 gives q=-3, r=-1. 7/-2 gives q=-3, r=1.
- Divide by zero (den=0):
  - o_divzero=1 and o_ovf=0.
  - o_quot = 2^(OUT_W-1)-1 if num ≥ 0, else -2^(OUT_W-1). Same for either SATURATE value.
  - o_rem = low DEN_W bits of num.
- Overflow (den≠0, exact quotient outside [-2^(OUT_W-1), 2^(OUT_W-1)-1]):
  - o_ovf=1.
  - SATURATE=1: clamp to the nearest bound.
  - SATURATE=0: low OUT_W bits of the exact quotient.
  - Includes the case -2^(NUM_W-1) / -1 (exact +2^(NUM_W-1)).
- No combinational path from any input to any output.

Test Plan:
- Defaults, i_enable=1: issue 1000/7, tag 0x11 → exactly 6 cycles later o_valid=1, o_quot=142, o_rem=6, o_tag=0x11, both flags 0.
- Sign handling:
  - -1000/7 → q=-142, r=-6
  - 1000/-7 → q=-142, r=6
  - -1000/-7 → q=142, r=-6
- Divide by zero:
  - 5/0 → o_quot=0x7FFFF, o_divzero=1
  - -5/0 → o_quot=0x80000, o_divzero=1
  - 0/0 → o_quot=0x7FFFF, o_divzero=1
- Overflow, 0x10000000/1:
  - SATURATE=1 → o_quot=0x7FFFF, o_ovf=1
  - SATURATE=0 → o_quot=0x00000, o_ovf=1
- Overflow, 0x80000000/-1:
  - SATURATE=1 → 0x7FFFF, o_ovf=1
- Streaming: 64 random ops with tags 0..63, i_enable pseudo-random at 50% → results match a reference model, in order, no drops or duplicates. Each result appears after 6 enabled edges; outputs are frozen while i_enable=0.
- Reset mid-flight: issue 3 ops, assert reset asynchronously between edges → o_valid falls to 0 immediately, and stays 0 for 6+ cycles after release with no new issues.
